// File: rtl/mem_arb_2p.sv
// Two-port request/grant arbiter sharing one single-port synchronous memory between fetch (read) and load/store.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arb_2p #(
  parameter int AW       = 9,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [DW-1:0] ls_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("mem_arb_2p: MAX_WAIT must be in 1..15");
  end

  // Handshake: a requester holds req/addr/we/wdata stable until gnt=1; the
  // access is consumed at that rising edge, and req high afterwards is a new access.

  // {fetch read, load read} issued last cycle; qualifies mem_dout this cycle.
  logic [1:0] rd_tag;
  logic       force_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] wait_cnt;

  assign force_if = if_req && (wait_cnt == 4'(MAX_WAIT));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wait_cnt <= '0;
    end else if (if_req && !if_gnt) begin
      wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    ls_gnt = rst_b & ls_req & ~force_if;
    if_gnt = rst_b & if_req & ~ls_gnt;
  end

  always_comb begin
    mem_we   = ls_gnt & ls_we;
    mem_addr = '0;
    mem_din  = '0;
    if (ls_gnt) begin
      mem_addr = ls_addr;
      mem_din  = ls_wdata;
    end else if (if_gnt) begin
      mem_addr = if_addr;
      mem_din  = ls_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_tag <= 2'b00;
    end else begin
      rd_tag <= {if_gnt, ls_gnt & ~ls_we};
    end
  end

  assign if_rvalid = rd_tag[1];
  assign ls_rvalid = rd_tag[0];
  assign if_rdata  = rd_tag[1] ? mem_dout : '0;
  assign ls_rdata  = rd_tag[0] ? mem_dout : '0;

endmodule

// File: tb/tb_mem_arb_2p.sv
// Directed self-checking bench for mem_arb_2p with a behavioural 512x16 synchronous memory.
module tb_mem_arb_2p;
  localparam int AW = 9;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  logic [DW-1:0] mem [512];

  int tests_run    = 0;
  int tests_failed = 0;
  logic [DW-1:0] exp_q[$];

  // clock / memory model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    else if (pre_en) mem[pre_addr] <= pre_data;
    mem_dout <= mem[mem_addr];
  end

  mem_arb_2p #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_b(rst_b),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    if_req   = 1'b0;
    if_addr  = '0;
    ls_req   = 1'b0;
    ls_we    = 1'b0;
    ls_addr  = '0;
    ls_wdata = '0;
  endtask

  task automatic drive_fetch(input logic [AW-1:0] a);
    if_req  = 1'b1;
    if_addr = a;
  endtask

  task automatic drive_ls(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ls_req   = 1'b1;
    ls_we    = we;
    ls_addr  = a;
    ls_wdata = d;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    next_cycle();
    pre_en   = 1'b0;
  endtask

  task automatic test_reset();
    drive_fetch(9'h005);
    drive_ls(1'b0, 9'h020, 16'h0);
    @(negedge clk);
    tests_run++;
    if ({if_gnt, ls_gnt, mem_we, if_rvalid, ls_rvalid} !== 5'b0 || mem_addr !== '0 ||
        mem_din !== '0 || if_rdata !== '0 || ls_rdata !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got gnt=%b%b we=%b rv=%b%b addr=%h din=%h want all 0",
               if_gnt, ls_gnt, mem_we, if_rvalid, ls_rvalid, mem_addr, mem_din);
    end
    drive_idle();
    next_cycle();
    rst_b = 1'b1;
    next_cycle();
    // fetch granted, then reset lands before the edge
    drive_fetch(9'h005);
    @(negedge clk);
    tests_run++;
    if (if_gnt !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_pre_gnt: got %b want 1", if_gnt);
    end
    #1 rst_b = 1'b0;
    #1;
    tests_run++;
    if (if_gnt !== 1'b0 || mem_addr !== '0) begin
      tests_failed++;
      $display("FAIL reset_gnt_gated: got gnt=%b addr=%h want 0 0", if_gnt, mem_addr);
    end
    next_cycle();
    tests_run++;
    if (if_rvalid !== 1'b0 || if_rdata !== '0 || ls_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_no_rvalid: got rv=%b%b rdata=%h want 0", if_rvalid, ls_rvalid, if_rdata);
    end
    rst_b = 1'b1;
    drive_idle();
    @(negedge clk);
    tests_run++;
    if (if_rvalid !== 1'b0 || ls_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_rvalid: got %b%b want 00", if_rvalid, ls_rvalid);
    end
    next_cycle();
    drive_fetch(9'h000);
    @(negedge clk);
    tests_run++;
    if (if_gnt !== 1'b1 || mem_addr !== 9'h000) begin
      tests_failed++;
      $display("FAIL reset_first_fetch_gnt: got gnt=%b addr=%h want 1 000", if_gnt, mem_addr);
    end
    next_cycle();
    drive_idle();
    @(negedge clk);
    tests_run++;
    if (if_rvalid !== 1'b1 || if_rdata !== 16'h00A0) begin
      tests_failed++;
      $display("FAIL reset_first_fetch_data: got rv=%b data=%h want 1 00a0", if_rvalid, if_rdata);
    end
    next_cycle();
  endtask

  task automatic test_write_readback();
    drive_ls(1'b1, 9'h1A5, 16'hBEEF);
    @(negedge clk);
    tests_run++;
    if (ls_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 9'h1A5 || mem_din !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL wr_grant: got gnt=%b we=%b addr=%h din=%h want 1 1 1a5 beef",
               ls_gnt, mem_we, mem_addr, mem_din);
    end
    next_cycle();
    drive_ls(1'b0, 9'h1A5, 16'h0);
    @(negedge clk);
    tests_run++;
    if (ls_gnt !== 1'b1 || mem_we !== 1'b0 || ls_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_grant: got gnt=%b we=%b rv=%b want 1 0 0", ls_gnt, mem_we, ls_rvalid);
    end
    next_cycle();
    drive_idle();
    @(negedge clk);
    tests_run++;
    if (ls_rvalid !== 1'b1 || ls_rdata !== 16'hBEEF || if_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_readback: got rv=%b data=%h if_rv=%b want 1 beef 0", ls_rvalid, ls_rdata, if_rvalid);
    end
    next_cycle();
  endtask

  task automatic test_simultaneous();
    drive_fetch(9'h010);
    drive_ls(1'b0, 9'h020, 16'h0);
    @(negedge clk);
    tests_run++;
    if (ls_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_addr !== 9'h020) begin
      tests_failed++;
      $display("FAIL simul_c0: got ls=%b if=%b addr=%h want 1 0 020", ls_gnt, if_gnt, mem_addr);
    end
    next_cycle();
    ls_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if (ls_rvalid !== 1'b1 || ls_rdata !== 16'h5678 || if_gnt !== 1'b1 || mem_addr !== 9'h010) begin
      tests_failed++;
      $display("FAIL simul_c1: got rv=%b data=%h if_gnt=%b addr=%h want 1 5678 1 010",
               ls_rvalid, ls_rdata, if_gnt, mem_addr);
    end
    next_cycle();
    drive_idle();
    @(negedge clk);
    tests_run++;
    if (if_rvalid !== 1'b1 || if_rdata !== 16'h1234 || ls_rvalid !== 1'b0 || ls_rdata !== '0) begin
      tests_failed++;
      $display("FAIL simul_c2: got if_rv=%b data=%h ls_rv=%b ls_data=%h want 1 1234 0 0",
               if_rvalid, if_rdata, ls_rvalid, ls_rdata);
    end
    next_cycle();
  endtask

  task automatic test_pipelined_fetch();
    logic [DW-1:0] e;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive_fetch(AW'(i));
      else drive_idle();
      @(negedge clk);
      if (i < 4) begin
        tests_run++;
        if (if_gnt !== 1'b1) begin
          tests_failed++;
          $display("FAIL pipe_gnt_%0d: got %b want 1", i, if_gnt);
        end
      end
      if (i > 0) begin
        e = exp_q.pop_front();
        tests_run++;
        if (if_rvalid !== 1'b1 || if_rdata !== e) begin
          tests_failed++;
          $display("FAIL pipe_data_%0d: got rv=%b data=%h want 1 %h", i, if_rvalid, if_rdata, e);
        end
      end
      if (i < 4) exp_q.push_back(16'h00A0 + DW'(i));
      next_cycle();
    end
    @(negedge clk);
    tests_run++;
    if (if_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL pipe_end: got rv=%b want 0", if_rvalid);
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    logic exp_if, prev_if, prev_ls;
    int n;
`ifdef MEM_ARB_STARVE_GUARD_EN
    n = 10;
`else
    n = 20;
`endif
    prev_if = 1'b0;
    prev_ls = 1'b0;
    drive_fetch(9'h010);
    drive_ls(1'b0, 9'h020, 16'h0);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_if = (c % 5 == 0);
`else
      exp_if = 1'b0;
`endif
      tests_run++;
      if (if_gnt !== exp_if || ls_gnt !== !exp_if) begin
        tests_failed++;
        $display("FAIL starve_gnt_c%0d: got if=%b ls=%b want %b %b", c, if_gnt, ls_gnt, exp_if, !exp_if);
      end
      tests_run++;
      if (if_rvalid !== prev_if || ls_rvalid !== prev_ls ||
          (prev_if && if_rdata !== 16'h1234) || (prev_ls && ls_rdata !== 16'h5678)) begin
        tests_failed++;
        $display("FAIL starve_rsp_c%0d: got rv=%b%b want %b%b", c, if_rvalid, ls_rvalid, prev_if, prev_ls);
      end
      prev_if = exp_if;
      prev_ls = !exp_if;
      next_cycle();
    end
    drive_idle();
    next_cycle();
  endtask

  task automatic test_write_no_response();
    logic [DW-1:0] e;
    for (int i = 0; i < 3; i++) begin
      drive_ls(1'b1, 9'h100 + AW'(i), 16'hC001 + DW'(i));
      @(negedge clk);
      tests_run++;
      if (mem_we !== 1'b1 || ls_gnt !== 1'b1 || mem_addr !== 9'h100 + AW'(i) ||
          ls_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
        tests_failed++;
        $display("FAIL wr3_c%0d: got we=%b gnt=%b addr=%h rv=%b%b want 1 1 %h 00",
                 i, mem_we, ls_gnt, mem_addr, if_rvalid, ls_rvalid, 9'h100 + AW'(i));
      end
      next_cycle();
    end
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive_ls(1'b0, 9'h100 + AW'(i), 16'h0);
      else drive_idle();
      @(negedge clk);
      if (i == 0) begin
        tests_run++;
        if (ls_rvalid !== 1'b0) begin
          tests_failed++;
          $display("FAIL wr3_no_rsp: got rv=%b want 0", ls_rvalid);
        end
      end else begin
        e = exp_q.pop_front();
        tests_run++;
        if (ls_rvalid !== 1'b1 || ls_rdata !== e) begin
          tests_failed++;
          $display("FAIL wr3_read_%0d: got rv=%b data=%h want 1 %h", i, ls_rvalid, ls_rdata, e);
        end
      end
      if (i < 3) exp_q.push_back(16'hC001 + DW'(i));
      next_cycle();
    end
  endtask

  task automatic test_idle();
    drive_idle();
    @(negedge clk);
    tests_run++;
    if (if_gnt !== 1'b0 || ls_gnt !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_din !== '0) begin
      tests_failed++;
      $display("FAIL idle_drive: got gnt=%b%b we=%b addr=%h din=%h want 0",
               if_gnt, ls_gnt, mem_we, mem_addr, mem_din);
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (if_rvalid !== 1'b0 || ls_rvalid !== 1'b0 || if_rdata !== '0 || ls_rdata !== '0) begin
      tests_failed++;
      $display("FAIL idle_rvalid: got rv=%b%b want 00", if_rvalid, ls_rvalid);
    end
    next_cycle();
  endtask

  initial begin
    rst_b  = 1'b0;
    pre_en = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    drive_idle();
    next_cycle();
    for (int i = 0; i < 4; i++) preload(AW'(i), 16'h00A0 + DW'(i));
    preload(9'h005, 16'h5555);
    preload(9'h010, 16'h1234);
    preload(9'h020, 16'h5678);
    test_reset();
    test_write_readback();
    test_simultaneous();
    test_pipelined_fetch();
    test_starvation();
    test_write_no_response();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
